// File: rtl/uart_tx_rr_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_PORTS AXI-stream byte
// sources into the single UART TX stream; a grant lasts until tlast or MAX_BURST bytes.
module uart_tx_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic                            grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_idx
);
    // state | meaning
    // IDLE  | no owner; pick the next requester after last_grant
    // XFER  | granted port is muxed straight through to the UART TX
    typedef enum logic {IDLE, XFER} state_t;

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_PORTS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   pick;
    logic               limit_hit;
    logic               handshake;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Descending scan so the nearest port after last_grant wins.
    always_comb begin
        pick = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (s_axis_tvalid[(int'(last_q) + k) % NUM_PORTS])
                pick = IDX_W'((int'(last_q) + k) % NUM_PORTS);
        end
    end

    assign limit_hit = (MAX_BURST != 0) && (cnt_q == BURST_LAST);
    assign handshake = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (handshake) begin
                    if (m_axis_tlast) begin
                        last_d  = grant_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == XFER) begin
            m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q] | limit_hit;
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign grant_valid = (state_q == XFER);
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Directed bench for uart_tx_rr_arbiter (4 ports, 8-bit data, MAX_BURST=16).
module tb_uart_tx_rr_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        grant_valid;
    logic [1:0]  grant_idx;

    int checks = 0;
    int errors = 0;

    uart_tx_rr_arbiter #(.DATA_WIDTH(8), .NUM_PORTS(4), .MAX_BURST(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input logic [7:0] d, input logic v, input logic l);
        s_tdata[p*8 +: 8] = d;
        s_tvalid[p]       = v;
        s_tlast[p]        = l;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        #1;
        check("rst_grant_valid", {31'd0, grant_valid}, 32'd0);
        check("rst_grant_idx", {30'd0, grant_idx}, 32'd0);
        check("rst_outputs", {22'd0, m_tvalid, m_tlast, m_tdata}, 32'd0);
        check("rst_tready", {28'd0, s_tready}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;

        // 1: all four ports with 1-byte packets, served 0..3 with an IDLE gap each
        for (int i = 0; i < 4; i++) setp(i, 8'(8'h10 + i), 1'b1, 1'b1);
        m_tready = 1'b1;
        #1;
        check("t1_idle_no_xfer", {30'd0, grant_valid, m_tvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t1_grant", {29'd0, grant_valid, grant_idx}, {29'd0, 1'b1, 2'(i)});
            check("t1_data", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, 1'b1, 8'(8'h10 + i)});
            check("t1_tready", {28'd0, s_tready}, 32'd1 << i);
            cyc();
            s_tvalid[i] = 1'b0;
            #1;
            check("t1_gap", {31'd0, grant_valid}, 32'd0);
        end

        // 2: port2 3-byte packet, port1 arrives at byte 2 and waits
        setp(2, 8'hA1, 1'b1, 1'b0);
        cyc();
        check("t2_b1", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd2, 1'b0, 8'hA1});
        cyc();
        setp(2, 8'hA2, 1'b1, 1'b0);
        setp(1, 8'hB1, 1'b1, 1'b1);
        #1;
        check("t2_b2", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0100, 2'd2, 1'b0, 8'hA2});
        cyc();
        setp(2, 8'hA3, 1'b1, 1'b1);
        #1;
        check("t2_b3", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0100, 2'd2, 1'b1, 8'hA3});
        cyc();
        s_tvalid[2] = 1'b0;
        #1;
        check("t2_gap", {31'd0, grant_valid}, 32'd0);
        cyc();
        check("t2_port1", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0010, 2'd1, 1'b1, 8'hB1});
        cyc();
        s_tvalid[1] = 1'b0;

        // 3: port0 20-byte packet split at 16 bytes, port3 served in between
        setp(0, 8'd1, 1'b1, 1'b0);
        cyc();
        check("t3_grant0", {29'd0, grant_valid, grant_idx}, {29'd0, 1'b1, 2'd0});
        setp(3, 8'hC3, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            #1;
            check("t3_burst", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd0, (k == 16), 8'(k)});
            cyc();
            setp(0, 8'(k + 1), 1'b1, 1'b0);
        end
        #1;
        check("t3_release", {31'd0, grant_valid}, 32'd0);
        cyc();
        check("t3_port3", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd3, 1'b1, 8'hC3});
        cyc();
        s_tvalid[3] = 1'b0;
        cyc();
        for (int k = 17; k <= 20; k++) begin
            #1;
            check("t3_tail", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd0, (k == 20), 8'(k)});
            cyc();
            setp(0, 8'(k + 1), 1'b1, (k + 1 == 20));
        end
        s_tvalid[0] = 1'b0;
        #1;
        check("t3_done", {31'd0, grant_valid}, 32'd0);

        // 4: downstream stall for 10 cycles mid-packet on port1
        setp(1, 8'hD1, 1'b1, 1'b0);
        cyc();
        check("t4_b1", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd1, 1'b0, 8'hD1});
        cyc();
        setp(1, 8'hD2, 1'b1, 1'b0);
        m_tready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t4_stall", {17'd0, s_tready, grant_valid, grant_idx, m_tvalid, m_tdata},
                  {17'd0, 4'b0000, 1'b1, 2'd1, 1'b1, 8'hD2});
            cyc();
        end
        m_tready = 1'b1;
        #1;
        check("t4_resume", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0010, 2'd1, 1'b0, 8'hD2});
        cyc();
        setp(1, 8'hD3, 1'b1, 1'b1);
        #1;
        check("t4_b3", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd1, 1'b1, 8'hD3});
        cyc();
        s_tvalid[1] = 1'b0;

        // 5: reset hits byte 2 of a port1 packet; port0 wins afterwards
        setp(1, 8'hE1, 1'b1, 1'b0);
        cyc();
        check("t5_grant1", {29'd0, grant_valid, grant_idx}, {29'd0, 1'b1, 2'd1});
        cyc();
        setp(1, 8'hE2, 1'b1, 1'b0);
        setp(0, 8'hF0, 1'b1, 1'b1);
        #1;
        check("t5_b2", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd1, 1'b0, 8'hE2});
        rst = 1'b1;
        #1;
        check("t5_rst_now", {18'd0, s_tready, grant_valid, m_tvalid, m_tdata}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("t5_post_idle", {31'd0, grant_valid}, 32'd0);
        cyc();
        check("t5_port0_first", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd0, 1'b1, 8'hF0});
        cyc();
        s_tvalid[0] = 1'b0;
        setp(1, 8'hE2, 1'b1, 1'b1);
        cyc();
        check("t5_port1", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd1, 1'b1, 8'hE2});
        cyc();
        s_tvalid[1] = 1'b0;

        // 6: port0 drops tvalid mid-packet for 5 cycles, port1 kept waiting
        setp(0, 8'h61, 1'b1, 1'b0);
        setp(1, 8'h71, 1'b1, 1'b1);
        cyc();
        check("t6_grant0", {22'd0, grant_idx, m_tlast, m_tdata}, {22'd0, 2'd0, 1'b0, 8'h61});
        cyc();
        s_tvalid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t6_hold", {24'd0, s_tready, grant_valid, grant_idx, m_tvalid},
                  {24'd0, 4'b0001, 1'b1, 2'd0, 1'b0});
            cyc();
        end
        setp(0, 8'h62, 1'b1, 1'b1);
        #1;
        check("t6_b2", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0001, 2'd0, 1'b1, 8'h62});
        cyc();
        s_tvalid[0] = 1'b0;
        #1;
        check("t6_gap", {31'd0, grant_valid}, 32'd0);
        cyc();
        check("t6_port1", {20'd0, s_tready, grant_idx, m_tlast, m_tdata}, {20'd0, 4'b0010, 2'd1, 1'b1, 8'h71});
        cyc();
        s_tvalid[1] = 1'b0;
        #1;
        check("t6_done", {31'd0, grant_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
